// File: rtl/stage_wb.sv
// Writeback/commit stage: retires one TLWB bundle per cycle. It commits
// register writes, turns jumps/taken branches/iret into fetch redirects, takes
// TLB-miss and privilege exceptions, performs TLB fills, and keeps per-thread
// privilege and exception registers. A per-thread squash filter discards
// wrong-path instructions still in flight after a redirect.

package common;
  localparam int n_threads = 4;
  typedef enum logic [1:0] {
    TLBW_NONE = 2'd0,
    TLBW_ITLB = 2'd1,
    TLBW_DTLB = 2'd2
  } tlbwrite_t;
  typedef logic [19:0] vpn_t;
  typedef logic [19:0] ppn_t;
endpackage

module stage_wb
  import common::*;
#(
  parameter int          N_THREADS  = n_threads,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
  localparam int         TW         = $clog2(N_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TW-1:0]          wb_thread,
  input  logic                   wb_isvalid,
  input  logic                   wb_itlb_miss,
  input  logic                   wb_dtlb_miss,
  input  logic [4:0]             wb_dst,
  input  logic [31:0]            wb_pc,
  input  logic [31:0]            wb_r2,
  input  logic [31:0]            wb_data,
  input  logic [31:0]            wb_mul,
  input  logic                   wb_isequal,
  input  logic                   wb_flag_mul,
  input  logic                   wb_flag_reg,
  input  logic                   wb_flag_jump,
  input  logic                   wb_flag_branch,
  input  logic                   wb_flag_iret,
  input  tlbwrite_t              wb_flag_tlbwrite,
  output logic                   rf_wen,
  output logic [TW-1:0]          rf_thread,
  output logic [4:0]             rf_wdst,
  output logic [31:0]            rf_wdata,
  output logic                   redirect_en,
  output logic [TW-1:0]          redirect_thread,
  output logic [31:0]            redirect_pc,
  output logic                   itlb_write_en,
  output logic                   dtlb_write_en,
  output vpn_t                   tlb_write_vpn,
  output ppn_t                   tlb_write_ppn,
  output logic [N_THREADS-1:0]   mode,
  output logic [N_THREADS*32-1:0] rm0,
  output logic [N_THREADS*32-1:0] rm1,
  output logic [N_THREADS*32-1:0] rm2
);

  // Per-thread architectural and squash state
  logic        sq_active_q [N_THREADS];
  logic [31:0] sq_pc_q     [N_THREADS];
  logic        mode_q      [N_THREADS];
  logic [31:0] rm0_q       [N_THREADS];
  logic [31:0] rm1_q       [N_THREADS];
  logic [31:0] rm2_q       [N_THREADS];

  // Registered output ports
  logic          rf_wen_q, rf_wen_d;
  logic [TW-1:0] rf_thread_q, rf_thread_d;
  logic [4:0]    rf_wdst_q, rf_wdst_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          redirect_en_q, redirect_en_d;
  logic [TW-1:0] redirect_thread_q, redirect_thread_d;
  logic [31:0]   redirect_pc_q, redirect_pc_d;
  logic          itlb_write_en_q, itlb_write_en_d;
  logic          dtlb_write_en_q, dtlb_write_en_d;
  vpn_t          tlb_write_vpn_q, tlb_write_vpn_d;
  ppn_t          tlb_write_ppn_q, tlb_write_ppn_d;

  // Decode of the incoming bundle
  logic        pc_match;
  logic        sq_release;
  logic        live;
  logic        priv_fault;
  logic        take_exc;
  logic        commit;
  logic        do_iret;
  logic        do_branch;
  logic        redir;
  logic [31:0] redir_target;
  logic [31:0] exc_cause;
  logic [31:0] exc_addr;

  // Classify the bundle: squash filter, exception priority, commit actions
  always_comb begin
    pc_match     = (wb_pc == sq_pc_q[wb_thread]);
    sq_release   = sq_active_q[wb_thread] & pc_match;
    live         = ~(sq_active_q[wb_thread] & ~pc_match)
                 & (wb_isvalid | wb_itlb_miss | wb_dtlb_miss);
    priv_fault   = (wb_flag_iret | (wb_flag_tlbwrite != TLBW_NONE))
                 & ~mode_q[wb_thread];
    take_exc     = live & (wb_itlb_miss | wb_dtlb_miss | priv_fault);
    commit       = live & ~take_exc;
    do_iret      = commit & wb_flag_iret;
    do_branch    = commit & (wb_flag_jump | (wb_flag_branch & wb_isequal));
    redir        = take_exc | do_iret | do_branch;
    exc_cause    = 32'd3;
    exc_addr     = wb_pc;
    if (wb_itlb_miss) begin
      exc_cause = 32'd1;
      exc_addr  = wb_pc;
    end else if (wb_dtlb_miss) begin
      exc_cause = 32'd2;
      exc_addr  = wb_data;
    end
    // iret takes precedence over a jump flag should both ever be decoded
    if (take_exc)     redir_target = EXC_VECTOR;
    else if (do_iret) redir_target = rm0_q[wb_thread];
    else              redir_target = wb_data;
  end

  // Next values of the output ports; data fields read zero when idle
  always_comb begin
    rf_wen_d          = commit & wb_flag_reg;
    rf_thread_d       = '0;
    rf_wdst_d         = '0;
    rf_wdata_d        = '0;
    redirect_en_d     = redir;
    redirect_thread_d = '0;
    redirect_pc_d     = '0;
    itlb_write_en_d   = commit & (wb_flag_tlbwrite == TLBW_ITLB);
    dtlb_write_en_d   = commit & (wb_flag_tlbwrite == TLBW_DTLB);
    tlb_write_vpn_d   = '0;
    tlb_write_ppn_d   = '0;
    if (rf_wen_d) begin
      rf_thread_d = wb_thread;
      rf_wdst_d   = wb_dst;
      rf_wdata_d  = wb_flag_mul ? wb_mul : wb_data;
    end
    if (redir) begin
      redirect_thread_d = wb_thread;
      redirect_pc_d     = redir_target;
    end
    if (itlb_write_en_d | dtlb_write_en_d) begin
      tlb_write_vpn_d = wb_r2[31:12];
      tlb_write_ppn_d = wb_data[$bits(ppn_t)-1:0];
    end
  end

  // Output port registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wen_q          <= 1'b0;
      rf_thread_q       <= '0;
      rf_wdst_q         <= '0;
      rf_wdata_q        <= '0;
      redirect_en_q     <= 1'b0;
      redirect_thread_q <= '0;
      redirect_pc_q     <= '0;
      itlb_write_en_q   <= 1'b0;
      dtlb_write_en_q   <= 1'b0;
      tlb_write_vpn_q   <= '0;
      tlb_write_ppn_q   <= '0;
    end else begin
      rf_wen_q          <= rf_wen_d;
      rf_thread_q       <= rf_thread_d;
      rf_wdst_q         <= rf_wdst_d;
      rf_wdata_q        <= rf_wdata_d;
      redirect_en_q     <= redirect_en_d;
      redirect_thread_q <= redirect_thread_d;
      redirect_pc_q     <= redirect_pc_d;
      itlb_write_en_q   <= itlb_write_en_d;
      dtlb_write_en_q   <= dtlb_write_en_d;
      tlb_write_vpn_q   <= tlb_write_vpn_d;
      tlb_write_ppn_q   <= tlb_write_ppn_d;
    end
  end

  assign rf_wen          = rf_wen_q;
  assign rf_thread       = rf_thread_q;
  assign rf_wdst         = rf_wdst_q;
  assign rf_wdata        = rf_wdata_q;
  assign redirect_en     = redirect_en_q;
  assign redirect_thread = redirect_thread_q;
  assign redirect_pc     = redirect_pc_q;
  assign itlb_write_en   = itlb_write_en_q;
  assign dtlb_write_en   = dtlb_write_en_q;
  assign tlb_write_vpn   = tlb_write_vpn_q;
  assign tlb_write_ppn   = tlb_write_ppn_q;

  for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_thread
    logic        sel;
    logic        sq_active_d;
    logic [31:0] sq_pc_d;
    logic        mode_d;
    logic [31:0] rm0_d;
    logic [31:0] rm1_d;
    logic [31:0] rm2_d;

    assign sel = (wb_thread == TW'(gi));

    // Thread-local next state; a redirect re-arms even if this instruction
    // just released the squash
    always_comb begin
      sq_active_d = sq_active_q[gi];
      sq_pc_d     = sq_pc_q[gi];
      mode_d      = mode_q[gi];
      rm0_d       = rm0_q[gi];
      rm1_d       = rm1_q[gi];
      rm2_d       = rm2_q[gi];
      if (sel) begin
        if (redir) begin
          sq_active_d = 1'b1;
          sq_pc_d     = redir_target;
        end else if (sq_release) begin
          sq_active_d = 1'b0;
        end
        if (take_exc) begin
          mode_d = 1'b1;
          rm0_d  = wb_pc;
          rm1_d  = exc_addr;
          rm2_d  = exc_cause;
        end else if (do_iret) begin
          mode_d = 1'b0;
        end
      end
    end

    // Thread-local state registers; threads boot in supervisor mode
    always_ff @(posedge clk) begin
      if (!rst) begin
        sq_active_q[gi] <= 1'b0;
        sq_pc_q[gi]     <= '0;
        mode_q[gi]      <= 1'b1;
        rm0_q[gi]       <= '0;
        rm1_q[gi]       <= '0;
        rm2_q[gi]       <= '0;
      end else begin
        sq_active_q[gi] <= sq_active_d;
        sq_pc_q[gi]     <= sq_pc_d;
        mode_q[gi]      <= mode_d;
        rm0_q[gi]       <= rm0_d;
        rm1_q[gi]       <= rm1_d;
        rm2_q[gi]       <= rm2_d;
      end
    end

    assign mode[gi]           = mode_q[gi];
    assign rm0[gi*32 +: 32]   = rm0_q[gi];
    assign rm1[gi*32 +: 32]   = rm1_q[gi];
    assign rm2[gi*32 +: 32]   = rm2_q[gi];
  end

endmodule

// File: tb/tb_stage_wb.sv
// Directed bench for stage_wb: register commit, branch squash, exceptions,
// TLB writes, iret, bubbles and reset during an active squash.
module tb_stage_wb;
  import common::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_thread;
  logic        wb_isvalid, wb_itlb_miss, wb_dtlb_miss;
  logic [4:0]  wb_dst;
  logic [31:0] wb_pc, wb_r2, wb_data, wb_mul;
  logic        wb_isequal, wb_flag_mul, wb_flag_reg, wb_flag_jump;
  logic        wb_flag_branch, wb_flag_iret;
  tlbwrite_t   wb_flag_tlbwrite;
  logic        rf_wen;
  logic [1:0]  rf_thread;
  logic [4:0]  rf_wdst;
  logic [31:0] rf_wdata;
  logic        redirect_en;
  logic [1:0]  redirect_thread;
  logic [31:0] redirect_pc;
  logic        itlb_write_en, dtlb_write_en;
  vpn_t        tlb_write_vpn;
  ppn_t        tlb_write_ppn;
  logic [3:0]  mode;
  logic [127:0] rm0, rm1, rm2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stage_wb dut (
    .clk(clk), .rst(rst), .wb_thread(wb_thread), .wb_isvalid(wb_isvalid),
    .wb_itlb_miss(wb_itlb_miss), .wb_dtlb_miss(wb_dtlb_miss), .wb_dst(wb_dst),
    .wb_pc(wb_pc), .wb_r2(wb_r2), .wb_data(wb_data), .wb_mul(wb_mul),
    .wb_isequal(wb_isequal), .wb_flag_mul(wb_flag_mul), .wb_flag_reg(wb_flag_reg),
    .wb_flag_jump(wb_flag_jump), .wb_flag_branch(wb_flag_branch),
    .wb_flag_iret(wb_flag_iret), .wb_flag_tlbwrite(wb_flag_tlbwrite),
    .rf_wen(rf_wen), .rf_thread(rf_thread), .rf_wdst(rf_wdst), .rf_wdata(rf_wdata),
    .redirect_en(redirect_en), .redirect_thread(redirect_thread),
    .redirect_pc(redirect_pc), .itlb_write_en(itlb_write_en),
    .dtlb_write_en(dtlb_write_en), .tlb_write_vpn(tlb_write_vpn),
    .tlb_write_ppn(tlb_write_ppn), .mode(mode), .rm0(rm0), .rm1(rm1), .rm2(rm2)
  );

  task automatic clr();
    wb_thread = 2'd0; wb_isvalid = 1'b0; wb_itlb_miss = 1'b0; wb_dtlb_miss = 1'b0;
    wb_dst = 5'd0; wb_pc = 32'd0; wb_r2 = 32'd0; wb_data = 32'd0; wb_mul = 32'd0;
    wb_isequal = 1'b0; wb_flag_mul = 1'b0; wb_flag_reg = 1'b0; wb_flag_jump = 1'b0;
    wb_flag_branch = 1'b0; wb_flag_iret = 1'b0; wb_flag_tlbwrite = TLBW_NONE;
  endtask

  // Present the current bundle for one edge, then step just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
    $display("txn t=%0d pc=%h v=%0d -> rf_wen=%0d wdata=%h redir=%0d rpc=%h mode=%b",
             wb_thread, wb_pc, wb_isvalid, rf_wen, rf_wdata, redirect_en, redirect_pc, mode);
  endtask

  task automatic test_reset();
    clr();
    rst = 1'b0;
    tick(); tick();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); end
    checks++; if (redirect_en !== 1'b0 || redirect_pc !== 32'd0) begin failures++; $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect_en, redirect_pc); end
    checks++; if (mode !== 4'hF) begin failures++; $display("FAIL reset_mode got=%b exp=1111", mode); end
    checks++; if (rm0 !== '0 || rm1 !== '0 || rm2 !== '0) begin failures++; $display("FAIL reset_rm got=%h/%h/%h exp=0", rm0, rm1, rm2); end
    checks++; if (itlb_write_en !== 1'b0 || dtlb_write_en !== 1'b0 || tlb_write_vpn !== '0) begin failures++; $display("FAIL reset_tlb got=%b%b/%h exp=00/0", itlb_write_en, dtlb_write_en, tlb_write_vpn); end
    rst = 1'b1;
  endtask

  task automatic test_reg_write();
    clr(); wb_thread = 2'd0; wb_isvalid = 1'b1; wb_pc = 32'h10; wb_flag_reg = 1'b1;
    wb_dst = 5'd5; wb_data = 32'h1234; wb_mul = 32'hBEEF;
    tick();
    checks++; if (rf_wen !== 1'b1 || rf_wdst !== 5'd5 || rf_thread !== 2'd0) begin failures++; $display("FAIL add_rf got=%b/%0d/%0d exp=1/5/0", rf_wen, rf_wdst, rf_thread); end
    checks++; if (rf_wdata !== 32'h1234) begin failures++; $display("FAIL add_wdata got=%h exp=00001234", rf_wdata); end
    checks++; if (redirect_en !== 1'b0) begin failures++; $display("FAIL add_noredir got=%b exp=0", redirect_en); end
    wb_pc = 32'h14; wb_flag_mul = 1'b1;
    tick();
    checks++; if (rf_wen !== 1'b1 || rf_wdata !== 32'hBEEF) begin failures++; $display("FAIL mul_wdata got=%b/%h exp=1/0000beef", rf_wen, rf_wdata); end
    // Not-taken branch: no redirect
    clr(); wb_isvalid = 1'b1; wb_pc = 32'h18; wb_flag_branch = 1'b1; wb_data = 32'h80;
    tick();
    checks++; if (redirect_en !== 1'b0) begin failures++; $display("FAIL nt_branch got=%b exp=0", redirect_en); end
  endtask

  task automatic test_branch_squash();
    clr(); wb_thread = 2'd1; wb_isvalid = 1'b1; wb_pc = 32'h100;
    wb_flag_branch = 1'b1; wb_isequal = 1'b1; wb_data = 32'h200;
    tick();
    checks++; if (redirect_en !== 1'b1 || redirect_thread !== 2'd1 || redirect_pc !== 32'h200) begin failures++; $display("FAIL br_redirect got=%b/%0d/%h exp=1/1/00000200", redirect_en, redirect_thread, redirect_pc); end
    clr(); wb_thread = 2'd1; wb_isvalid = 1'b1; wb_pc = 32'h104; wb_flag_reg = 1'b1; wb_dst = 5'd9; wb_data = 32'h11;
    tick();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL sq_104 got=%b exp=0", rf_wen); end
    wb_thread = 2'd0; wb_pc = 32'h40; wb_dst = 5'd7; wb_data = 32'h55;
    tick();
    checks++; if (rf_wen !== 1'b1 || rf_wdst !== 5'd7 || rf_wdata !== 32'h55) begin failures++; $display("FAIL other_thread got=%b/%0d/%h exp=1/7/00000055", rf_wen, rf_wdst, rf_wdata); end
    wb_thread = 2'd1; wb_pc = 32'h108; wb_flag_jump = 1'b1; wb_data = 32'h999;
    tick();
    checks++; if (rf_wen !== 1'b0 || redirect_en !== 1'b0) begin failures++; $display("FAIL sq_108 got=%b/%b exp=0/0", rf_wen, redirect_en); end
    clr(); wb_thread = 2'd1; wb_isvalid = 1'b1; wb_pc = 32'h200; wb_flag_reg = 1'b1; wb_dst = 5'd3; wb_data = 32'h77;
    tick();
    checks++; if (rf_wen !== 1'b1 || rf_thread !== 2'd1 || rf_wdata !== 32'h77) begin failures++; $display("FAIL target_commit got=%b/%0d/%h exp=1/1/00000077", rf_wen, rf_thread, rf_wdata); end
    wb_pc = 32'h204; wb_data = 32'h78;
    tick();
    checks++; if (rf_wen !== 1'b1 || rf_wdata !== 32'h78) begin failures++; $display("FAIL after_target got=%b/%h exp=1/00000078", rf_wen, rf_wdata); end
  endtask

  task automatic test_exceptions();
    // Drop thread 2 to user mode via iret (rm0 still 0)
    clr(); wb_thread = 2'd2; wb_isvalid = 1'b1; wb_pc = 32'h50; wb_flag_iret = 1'b1;
    tick();
    checks++; if (redirect_en !== 1'b1 || redirect_pc !== 32'h0 || mode !== 4'b1011) begin failures++; $display("FAIL iret0 got=%b/%h/%b exp=1/00000000/1011", redirect_en, redirect_pc, mode); end
    // Jump at the squash target re-arms the filter with its own target
    clr(); wb_thread = 2'd2; wb_isvalid = 1'b1; wb_pc = 32'h0; wb_flag_jump = 1'b1; wb_data = 32'h3000;
    tick();
    checks++; if (redirect_en !== 1'b1 || redirect_pc !== 32'h3000) begin failures++; $display("FAIL rearm got=%b/%h exp=1/00003000", redirect_en, redirect_pc); end
    clr(); wb_thread = 2'd2; wb_isvalid = 1'b1; wb_pc = 32'h4; wb_flag_reg = 1'b1; wb_dst = 5'd1; wb_data = 32'h1;
    tick();
    checks++; if (rf_wen !== 1'b0) begin failures++; $display("FAIL rearm_drop got=%b exp=0", rf_wen); end
    clr(); wb_thread = 2'd2; wb_isvalid = 1'b1; wb_itlb_miss = 1'b1; wb_dtlb_miss = 1'b1;
    wb_pc = 32'h3000; wb_data = 32'h9999; wb_flag_reg = 1'b1; wb_dst = 5'd4;
    tick();
    checks++; if (redirect_en !== 1'b1 || redirect_thread !== 2'd2 || redirect_pc !== 32'h2000) begin failures++; $display("FAIL itlb_redir got=%b/%0d/%h exp=1/2/00002000", redirect_en, redirect_thread, redirect_pc); end
    checks++; if (rm2[64 +: 32] !== 32'd1 || rm0[64 +: 32] !== 32'h3000 || rm1[64 +: 32] !== 32'h3000) begin failures++; $display("FAIL itlb_rm got=%h/%h/%h exp=1/3000/3000", rm2[64 +: 32], rm0[64 +: 32], rm1[64 +: 32]); end
    checks++; if (mode !== 4'hF || rf_wen !== 1'b0) begin failures++; $display("FAIL itlb_mode got=%b/%b exp=1111/0", mode, rf_wen); end
    // dtlb-only miss on supervisor thread 3: fault address is wb_data
    clr(); wb_thread = 2'd3; wb_isvalid = 1'b1; wb_dtlb_miss = 1'b1; wb_pc = 32'h400; wb_data = 32'hDEAD0;
    tick();
    checks++; if (rm2[96 +: 32] !== 32'd2 || rm1[96 +: 32] !== 32'hDEAD0 || rm0[96 +: 32] !== 32'h400) begin failures++; $display("FAIL dtlb_rm got=%h/%h/%h exp=2/dead0/400", rm2[96 +: 32], rm1[96 +: 32], rm0[96 +: 32]); end
    checks++; if (redirect_pc !== 32'h2000 || redirect_thread !== 2'd3) begin failures++; $display("FAIL dtlb_redir got=%h/%0d exp=00002000/3", redirect_pc, redirect_thread); end
  endtask

  task automatic test_tlbwrite();
    // Thread 2 is in supervisor and squashed to 0x2000 after its exception
    clr(); wb_thread = 2'd2; wb_isvalid = 1'b1; wb_pc = 32'h2000;
    wb_flag_tlbwrite = TLBW_DTLB; wb_r2 = 32'h0040_5000; wb_data = 32'h2A;
    tick();
    checks++; if (dtlb_write_en !== 1'b1 || itlb_write_en !== 1'b0) begin failures++; $display("FAIL tlbw_en got=%b%b exp=01", itlb_write_en, dtlb_write_en); end
    checks++; if (tlb_write_vpn !== 20'h00405 || tlb_write_ppn !== 20'h0002A) begin failures++; $display("FAIL tlbw_data got=%h/%h exp=00405/0002a", tlb_write_vpn, tlb_write_ppn); end
    clr(); wb_thread = 2'd2; wb_isvalid = 1'b1; wb_pc = 32'h2004; wb_flag_tlbwrite = TLBW_ITLB; wb_r2 = 32'hABCDE123; wb_data = 32'h7;
    tick();
    checks++; if (itlb_write_en !== 1'b1 || dtlb_write_en !== 1'b0 || tlb_write_vpn !== 20'hABCDE) begin failures++; $display("FAIL itlbw got=%b%b/%h exp=10/abcde", itlb_write_en, dtlb_write_en, tlb_write_vpn); end
    clr(); wb_thread = 2'd2; wb_isvalid = 1'b1; wb_pc = 32'h2008; wb_flag_iret = 1'b1;
    tick();
    checks++; if (redirect_en !== 1'b1 || redirect_pc !== 32'h3000 || mode !== 4'b1011 || itlb_write_en !== 1'b0) begin failures++; $display("FAIL iret got=%b/%h/%b exp=1/00003000/1011", redirect_en, redirect_pc, mode); end
    clr(); wb_thread = 2'd2; wb_isvalid = 1'b1; wb_pc = 32'h3000;
    wb_flag_tlbwrite = TLBW_DTLB; wb_r2 = 32'h0040_5000; wb_data = 32'h2A;
    tick();
    checks++; if (dtlb_write_en !== 1'b0 || rm2[64 +: 32] !== 32'd3) begin failures++; $display("FAIL priv got=%b/%h exp=0/3", dtlb_write_en, rm2[64 +: 32]); end
    checks++; if (redirect_pc !== 32'h2000 || mode !== 4'hF || rm1[64 +: 32] !== 32'h3000) begin failures++; $display("FAIL priv_state got=%h/%b/%h exp=2000/1111/3000", redirect_pc, mode, rm1[64 +: 32]); end
  endtask

  task automatic test_invalid();
    clr(); wb_thread = 2'd0; wb_pc = 32'h60; wb_flag_reg = 1'b1; wb_dst = 5'd6; wb_data = 32'h66; wb_flag_jump = 1'b1;
    tick();
    checks++; if (rf_wen !== 1'b0 || redirect_en !== 1'b0) begin failures++; $display("FAIL bubble got=%b/%b exp=0/0", rf_wen, redirect_en); end
  endtask

  task automatic test_reset_mid_squash();
    clr(); wb_thread = 2'd1; wb_isvalid = 1'b1; wb_pc = 32'h500; wb_flag_jump = 1'b1; wb_data = 32'h600;
    tick();
    checks++; if (redirect_en !== 1'b1 || redirect_pc !== 32'h600) begin failures++; $display("FAIL pre_rst_jump got=%b/%h exp=1/00000600", redirect_en, redirect_pc); end
    rst = 1'b0;
    tick();
    checks++; if (redirect_en !== 1'b0 || redirect_pc !== 32'h0 || mode !== 4'hF || rm2 !== '0) begin failures++; $display("FAIL mid_rst got=%b/%h/%b exp=0/0/1111", redirect_en, redirect_pc, mode); end
    rst = 1'b1;
    clr(); wb_thread = 2'd1; wb_isvalid = 1'b1; wb_pc = 32'h504; wb_flag_reg = 1'b1; wb_dst = 5'd2; wb_data = 32'hCAFE;
    tick();
    checks++; if (rf_wen !== 1'b1 || rf_wdata !== 32'hCAFE || rf_thread !== 2'd1) begin failures++; $display("FAIL post_rst got=%b/%h/%0d exp=1/0000cafe/1", rf_wen, rf_wdata, rf_thread); end
  endtask

  initial begin
    rst = 1'b0;
    clr();
    test_reset();
    test_reg_write();
    test_branch_squash();
    test_exceptions();
    test_tlbwrite();
    test_invalid();
    test_reset_mid_squash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stage_wb.md
# stage_wb

Writeback/commit stage for the multithreaded in-order datapath: consumes the per-cycle instruction bundle produced by the translation/lookup stage (TLWB bundle) and retires it. Commits register writes, resolves jumps/taken branches into fetch redirects, takes ITLB/DTLB-miss and privilege exceptions, executes `iret` and TLB writes, and holds per-thread privilege mode and exception registers. Keeps a per-thread squash filter so wrong-path instructions still in flight after a redirect are discarded.

## Interface
- `N_THREADS`, default `n_threads` from `common`: hardware thread count; `TW = $clog2(N_THREADS)`.
- `EXC_VECTOR`, default `32'h0000_2000`: exception handler PC.
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-low.
- `wb_thread` in, TW: thread id of incoming instruction.
- `wb_isvalid`, `wb_itlb_miss`, `wb_dtlb_miss` in, 1 each: valid, fetch-TLB miss, data-TLB miss.
- `wb_dst` in, 5: destination register.
- `wb_pc`, `wb_r2`, `wb_data`, `wb_mul` in, 32 each: PC, rs2 value, ALU/load result or target, multiplier result.
- `wb_isequal` in, 1: branch compare result.
- `wb_flag_mul`, `wb_flag_reg`, `wb_flag_jump`, `wb_flag_branch`, `wb_flag_iret` in, 1 each: decoded flags.
- `wb_flag_tlbwrite` in, `tlbwrite_t`: none / ITLB / DTLB.
- `rf_wen` out, 1; `rf_thread` out, TW; `rf_wdst` out, 5; `rf_wdata` out, 32: register-file write port.
- `redirect_en` out, 1; `redirect_thread` out, TW; `redirect_pc` out, 32: fetch redirect.
- `itlb_write_en`, `dtlb_write_en` out, 1 each; `tlb_write_vpn` out, `vpn_t`; `tlb_write_ppn` out, `ppn_t`: TLB fill ports, shared vpn/ppn.
- `mode` out, N_THREADS: per-thread privilege; 1 = supervisor.
- `rm0`, `rm1`, `rm2` out, N_THREADS×32 each: per-thread saved PC, fault address, cause.

## Operation
- Squash filter, per thread: `sq_active` flag and `sq_pc` register. An incoming instruction of thread t with `sq_active[t]` set is dropped (no side effects) unless `wb_pc == sq_pc[t]`. On a match, `sq_active[t]` clears and the instruction is processed normally.
- Instruction is *live* when it is not dropped and `wb_isvalid | wb_itlb_miss | wb_dtlb_miss`. Invalid with no miss (dcache miss, bubble) is ignored.
- Priority for a live instruction, highest first:
  - itlb_miss: cause 1, rm1 = wb_pc.
  - dtlb_miss: cause 2, rm1 = wb_data.
  - privilege fault: (`wb_flag_iret` or tlbwrite≠none) while `mode[t]=0`; cause 3, rm1 = wb_pc.
  - normal.
- Exception (causes 1–3): rm0[t] ← wb_pc, rm1[t] as above, rm2[t] ← cause, mode[t] ← 1, redirect to `EXC_VECTOR`. No register write, no TLB write.
- Normal commit:
  - rf write when `wb_flag_reg`: data is `wb_mul` if `wb_flag_mul`, else `wb_data`.
  - `wb_flag_jump`, or `wb_flag_branch & wb_isequal`: redirect to `wb_data`.
  - `wb_flag_iret`: redirect to rm0[t], mode[t] ← 0.
  - tlbwrite: vpn ← `wb_r2[31:12]`, ppn ← low `$bits(ppn_t)` bits of `wb_data`; assert the selected write enable.
- Any redirect for thread t sets `sq_active[t]` and `sq_pc[t]` ← redirect target.
- A redirect from an instruction that itself cleared the squash re-arms it with the new target.
- Other threads are unaffected.

## Timing
- All outputs registered; effects appear exactly 1 cycle after the input bundle.
- Enables are single-cycle pulses.
- Squash state updates on the same edge; the instruction in the next cycle is already filtered.
- One instruction per cycle; no backpressure, never stalls.
- Reset (any cycle, including mid-squash): all enables 0, `rf_*`/`redirect_*`/`tlb_*` data 0, `mode` all 1, rm0/rm1/rm2 0, all `sq_active` 0.

## Test plan
- Thread 0 add, `wb_flag_reg=1`, dst=5, data=0x1234 → next cycle `rf_wen=1`, `rf_wdst=5`, `rf_wdata=0x1234`. Repeat with `wb_flag_mul=1`, `wb_mul=0xBEEF` → `rf_wdata=0xBEEF`.
- Thread 1 taken branch at pc 0x100, target 0x200 → `redirect_pc=0x200`. Following thread-1 instructions at 0x104/0x108 produce no rf writes. Thread-0 instruction interleaved commits. Thread-1 pc 0x200 commits.
- User-mode thread 2, `itlb_miss` and `dtlb_miss` both at pc 0x3000 → rm2=1, rm0=0x3000, rm1=0x3000, mode[2]=1, `redirect_pc=0x2000`.
- Supervisor tlbwrite=DTLB, r2=0x0040_5000, data=0x2A → `dtlb_write_en=1`, vpn=0x00405, ppn=0x2A. Then `iret` → redirect to rm0, mode cleared. Same tlbwrite in user mode → cause 3, no write.
- `wb_isvalid=0`, no miss, `flag_reg=1` → no effects. Assert reset during an active squash → all outputs at reset values, next instruction of that thread commits.
